// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants, scan state type and glyph table for the
// seven-segment scan controller.
package seg7_pkg;

  localparam int NUM_DIGITS = 8;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [7:0] AN_OFF  = 8'hFF;

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } state_t;

  // Active-low glyphs, bit0 = CA .. bit6 = CG; entry [15] is written first.
  localparam logic [15:0][6:0] GLYPH = {
    7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
    7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
    7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
    7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
  };

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// seg7_scan_ctrl_if: host-side load bus of the scan controller.
// Defining SEG7_DIM_EN adds the dim_i brightness input.
interface seg7_scan_ctrl_if;
  logic [31:0] value_i;
  logic [7:0]  dp_i;
  logic [7:0]  blank_i;
  logic        load_i;
  logic        load_ack_o;
`ifdef SEG7_DIM_EN
  logic [3:0]  dim_i;
`endif

  modport master (
    output value_i, dp_i, blank_i, load_i,
`ifdef SEG7_DIM_EN
    output dim_i,
`endif
    input  load_ack_o
  );

  modport slave (
    input  value_i, dp_i, blank_i, load_i,
`ifdef SEG7_DIM_EN
    input  dim_i,
`endif
    output load_ack_o
  );
endinterface

// File: rtl/seg7_hex_enc.sv
// seg7_hex_enc: combinational nibble to active-low seven-segment glyph.
module seg7_hex_enc
  import seg7_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);
  assign seg = GLYPH[nib];
endmodule

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: 8-digit time-multiplexed common-anode display scanner with
// frame-synchronous double buffering. Define SEG7_DIM_EN for PWM dimming.
// BLANK_CYC must be at least 1 and below TICK_DIV; TICK_DIV at least 4.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int TICK_DIV  = 100_000,
  parameter int BLANK_CYC = 1_000
) (
  input  logic            clk,
  input  logic            rst_n,
  seg7_scan_ctrl_if.slave bus,
  output logic [7:0]      an_o,
  output logic [6:0]      seg_o,
  output logic            dp_o,
  output logic            frame_o
);
  localparam int CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYC - 1);

  logic [CNT_W-1:0] cnt;
  logic [2:0]       idx;
  logic             tick;
  logic             boundary;
  state_t           state_q, state_d;

  logic [31:0] active_val, pend_val;
  logic [7:0]  active_dp, pend_dp;
  logic [7:0]  active_blank, pend_blank;
  logic        pend_v;

  logic [3:0]  digit_nib;
  logic [6:0]  glyph_seg;
  logic        pwm_on;
  logic [7:0]  an_d;
  logic [6:0]  seg_d;
  logic        dp_d;

  assign tick     = (cnt == CNT_MAX);
  assign boundary = tick && (idx == 3'd7);

  assign digit_nib = active_val[{idx, 2'b00} +: 4];

  seg7_hex_enc u_enc (
    .nib (digit_nib),
    .seg (glyph_seg)
  );

`ifdef SEG7_DIM_EN
  logic [3:0] pwm;

  // Free-running PWM phase for brightness control.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pwm <= '0;
    else        pwm <= pwm + 4'd1;
  end

  // pwm < dim_i + 1 written without widening.
  assign pwm_on = (pwm <= bus.dim_i);
`else
  assign pwm_on = 1'b1;
`endif

  // Slot prescaler and digit index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else if (tick) begin
      cnt <= '0;
      idx <= idx + 3'd1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Scan state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= BLANK;
    else        state_q <= state_d;
  end

  // Next state and next registered display values.
  always_comb begin
    state_d = state_q;
    an_d    = AN_OFF;
    seg_d   = SEG_OFF;
    dp_d    = 1'b1;
    case (state_q)
      BLANK: if (cnt == BLANK_END && !tick) state_d = DRIVE;
      DRIVE: if (tick) state_d = BLANK;
      default: state_d = BLANK;
    endcase
    if (state_q == DRIVE) begin
      seg_d = glyph_seg;
      dp_d  = ~active_dp[idx];
      if (!active_blank[idx] && pwm_on) an_d = ~(8'(1) << idx);
    end
  end

  // Pending/active buffers; active only changes on the frame boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_val     <= '0;
      active_dp      <= '0;
      active_blank   <= '0;
      pend_val       <= '0;
      pend_dp        <= '0;
      pend_blank     <= '0;
      pend_v         <= 1'b0;
      bus.load_ack_o <= 1'b0;
      frame_o        <= 1'b0;
    end else begin
      bus.load_ack_o <= 1'b0;
      frame_o        <= boundary;
      if (boundary) begin
        if (bus.load_i) begin
          active_val     <= bus.value_i;
          active_dp      <= bus.dp_i;
          active_blank   <= bus.blank_i;
          bus.load_ack_o <= 1'b1;
        end else if (pend_v) begin
          active_val     <= pend_val;
          active_dp      <= pend_dp;
          active_blank   <= pend_blank;
          bus.load_ack_o <= 1'b1;
        end
        pend_v <= 1'b0;
      end else if (bus.load_i) begin
        pend_val   <= bus.value_i;
        pend_dp    <= bus.dp_i;
        pend_blank <= bus.blank_i;
        pend_v     <= 1'b1;
      end
    end
  end

  // Registered display outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_o  <= AN_OFF;
      seg_o <= SEG_OFF;
      dp_o  <= 1'b1;
    end else begin
      an_o  <= an_d;
      seg_o <= seg_d;
      dp_o  <= dp_d;
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl: self-checking bench for seg7_scan_ctrl with
// TICK_DIV=8, BLANK_CYC=2 and a cycle-count based reference model.
module tb_seg7_scan_ctrl;

  logic clk;
  logic rst_n;
  logic [7:0] an_o;
  logic [6:0] seg_o;
  logic dp_o;
  logic frame_o;

  seg7_scan_ctrl_if bus ();

  logic [31:0] drv_val;
  logic [7:0]  drv_dp;
  logic [7:0]  drv_blank;
  logic        drv_ld;
  assign bus.value_i = drv_val;
  assign bus.dp_i    = drv_dp;
  assign bus.blank_i = drv_blank;
  assign bus.load_i  = drv_ld;
`ifdef SEG7_DIM_EN
  logic [3:0] drv_dim;
  assign bus.dim_i = drv_dim;
`endif

  seg7_scan_ctrl #(.TICK_DIV(8), .BLANK_CYC(2)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .an_o    (an_o),
    .seg_o   (seg_o),
    .dp_o    (dp_o),
    .frame_o (frame_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int ack_cnt = 0;

  // Reference model: n = clock edges since reset release.
  int          n;
  logic [31:0] m_val, p_val;
  logic [7:0]  m_dp, p_dp, m_blank, p_blank;
  bit          p_v;
  logic [17:0] exp_vec;

  typedef struct {
    logic [31:0] val;
    logic [7:0]  dp;
    logic [7:0]  blank;
    logic [7:0]  exp_an;
    logic [6:0]  exp_seg;
    logic        exp_dp;
  } vec_t;
  vec_t tbl [6];

  function automatic logic [6:0] glyph(input logic [3:0] h);
    logic [6:0] hi;
    case (h)
      4'h0: hi = 7'h3F; 4'h1: hi = 7'h06; 4'h2: hi = 7'h5B; 4'h3: hi = 7'h4F;
      4'h4: hi = 7'h66; 4'h5: hi = 7'h6D; 4'h6: hi = 7'h7D; 4'h7: hi = 7'h07;
      4'h8: hi = 7'h7F; 4'h9: hi = 7'h6F; 4'hA: hi = 7'h77; 4'hB: hi = 7'h7C;
      4'hC: hi = 7'h39; 4'hD: hi = 7'h5E; 4'hE: hi = 7'h79; default: hi = 7'h71;
    endcase
    return ~hi;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    n = 0; m_val = '0; m_dp = '0; m_blank = '0;
    p_val = '0; p_dp = '0; p_blank = '0; p_v = 0;
  endtask

  // One clock: apply drv_* with load flag, advance model, compare at negedge.
  task automatic cycle(input logic ld);
    int pos, di;
    bit pwm_on, frm, ack;
    drv_ld = ld;
    @(posedge clk);
    pos = n % 8;
    di  = (n / 8) % 8;
`ifdef SEG7_DIM_EN
    pwm_on = ((n % 16) <= int'(drv_dim));
`else
    pwm_on = 1;
`endif
    frm = (n % 64 == 63);
    ack = 0;
    if (pos < 2) exp_vec[17:3] = {8'hFF, 7'h7F};
    else begin
      exp_vec[17:10] = (m_blank[di] || !pwm_on) ? 8'hFF : ~(8'h01 << di);
      exp_vec[9:3]   = glyph(m_val[di*4 +: 4]);
    end
    exp_vec[2] = (pos < 2) ? 1'b1 : ~m_dp[di];
    if (frm) begin
      if (ld) begin
        m_val = drv_val; m_dp = drv_dp; m_blank = drv_blank; ack = 1;
      end else if (p_v) begin
        m_val = p_val; m_dp = p_dp; m_blank = p_blank; ack = 1;
      end
      p_v = 0;
    end else if (ld) begin
      p_val = drv_val; p_dp = drv_dp; p_blank = drv_blank; p_v = 1;
    end
    exp_vec[1] = frm;
    exp_vec[0] = ack;
    n++;
    @(negedge clk);
    drv_ld = 1'b0;
    if (bus.load_ack_o === 1'b1) ack_cnt++;
    chk("scan{an,seg,dp,frame,ack}", {14'd0, an_o, seg_o, dp_o, frame_o, bus.load_ack_o},
        {14'd0, exp_vec});
  endtask

  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) cycle(1'b0);
  endtask

  // Advance until the next edge is frame position k (at most one frame).
  task automatic run_to(input int k);
    for (int i = 0; i < 64; i++) begin
      if (n % 64 == k) break;
      cycle(1'b0);
    end
  endtask

  task automatic set_drv(input logic [31:0] v, input logic [7:0] d, input logic [7:0] b);
    drv_val = v; drv_dp = d; drv_blank = b;
  endtask

  initial begin
    tbl[0] = '{32'h89AB_CDEF, 8'h01, 8'h00, 8'hFE, 7'h0E, 1'b0};
    tbl[1] = '{32'h1111_1111, 8'h00, 8'h00, 8'hFE, 7'h79, 1'b1};
    tbl[2] = '{32'h2222_2222, 8'h00, 8'h00, 8'hFE, 7'h24, 1'b1};
    tbl[3] = '{32'h0000_000B, 8'h00, 8'h00, 8'hFE, 7'h03, 1'b1};
    tbl[4] = '{32'h0000_0005, 8'h00, 8'h01, 8'hFF, 7'h12, 1'b1};
    tbl[5] = '{32'h0000_000C, 8'hFF, 8'h00, 8'hFE, 7'h46, 1'b0};

    rst_n = 1'b0;
    drv_ld = 1'b0;
    set_drv('0, '0, '0);
`ifdef SEG7_DIM_EN
    drv_dim = 4'hF;
`endif
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset_outputs", {14'd0, an_o, seg_o, dp_o, frame_o, bus.load_ack_o},
        {14'd0, 8'hFF, 7'h7F, 1'b1, 1'b0, 1'b0});
    rst_n = 1'b1;

    // Idle scan: two full frames of "0".
    run(128);

    // Table of mid-frame loads, each spot-checked on digit 0 of the next frame.
    for (int r = 0; r < 6; r++) begin
      set_drv(tbl[r].val, tbl[r].dp, tbl[r].blank);
      run_to(20);
      cycle(1'b1);
      run_to(0);
      run(3);
      chk($sformatf("tbl%0d_digit0", r), {24'd0, an_o}, {24'd0, tbl[r].exp_an});
      chk($sformatf("tbl%0d_seg", r), {25'd0, seg_o}, {25'd0, tbl[r].exp_seg});
      chk($sformatf("tbl%0d_dp", r), {31'd0, dp_o}, {31'd0, tbl[r].exp_dp});
    end

    // Two loads in one frame: single acknowledge, last value wins.
    run_to(10);
    ack_cnt = 0;
    set_drv(32'h1111_1111, 8'h00, 8'h00);
    cycle(1'b1);
    run_to(30);
    set_drv(32'h2222_2222, 8'h00, 8'h00);
    cycle(1'b1);
    run_to(0);
    run(64);
    chk("double_load_acks", ack_cnt, 1);

    // Load exactly on the boundary cycle: immediate, no extra ack later.
    run_to(63);
    ack_cnt = 0;
    set_drv(32'h3456_789A, 8'h80, 8'h00);
    cycle(1'b1);
    chk("boundary_load_ack", ack_cnt, 1);
    run(128);
    chk("boundary_no_extra_ack", ack_cnt, 1);

    // Upper digits blanked.
    set_drv(32'h7654_3210, 8'h00, 8'hF0);
    cycle(1'b1);
    run_to(0);
    run(64);

    // Randomized loads.
    for (int i = 0; i < 600; i++) begin
      set_drv($urandom, 8'($urandom), 8'($urandom));
      cycle(($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0);
    end

`ifdef SEG7_DIM_EN
    // Reduced brightness: model gates anode on pwm phase.
    drv_dim = 4'd3;
    run(128);
    drv_dim = 4'hF;
`endif

    // Asynchronous reset during digit 5 drive.
    set_drv(32'h5555_5555, 8'h00, 8'h00);
    cycle(1'b1);
    run_to(0);
    run_to(44);
    chk("pre_reset_an", {24'd0, an_o}, {24'd0, 8'hDF});
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", {14'd0, an_o, seg_o, dp_o, frame_o, bus.load_ack_o},
        {14'd0, 8'hFF, 7'h7F, 1'b1, 1'b0, 1'b0});
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    run(80);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
